// File: rtl/memory_word_transfer_unit.sv
// Moves one DATA_W word between a requester and a byte-wide synchronous memory,
// one byte per cycle, in little- or big-endian byte order.
//
// state  | meaning
// S_IDLE | waiting for i_start; memory deselected
// S_XFER | one byte per cycle, r_cnt = byte index
// S_DONE | one-cycle completion pulse, still busy
module memory_word_transfer_unit #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 16,
    parameter bit BIG_ENDIAN = 1'b0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_op,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [7:0]        i_mem_out,
    output logic [ADDR_W-1:0] o_mem_address,
    output logic [7:0]        o_mem_data,
    output logic              o_mem_wr,
    output logic              o_mem_cs,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_busy,
    output logic              o_done
);

    localparam int NBYTES = DATA_W / 8;
    localparam int CNT_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_op;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rbuf;
    logic [DATA_W-1:0]   r_rd_data;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_accept;
    logic                w_last;
    logic [CNT_W-1:0]    w_lane;
    logic [7:0]          w_wr_byte;
    logic [DATA_W-1:0]   w_rbuf_next;

    assign w_accept = (r_state == S_IDLE) && i_start;
    assign w_last   = (r_cnt == CNT_W'(NBYTES - 1));
    // Word byte lane touched by the current byte index; shared by load and store.
    assign w_lane   = BIG_ENDIAN ? (CNT_W'(NBYTES - 1) - r_cnt) : r_cnt;

    always_comb begin
        w_wr_byte   = 8'h00;
        w_rbuf_next = r_rbuf;
        for (int b = 0; b < NBYTES; b++) begin
            if (w_lane == CNT_W'(b)) begin
                w_wr_byte              = r_wdata[8*b +: 8];
                w_rbuf_next[8*b +: 8]  = i_mem_out;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_next = S_XFER;
            S_XFER:  if (w_last)  w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy     = (r_state != S_IDLE);
        o_done     = (r_state == S_DONE);
        o_mem_cs   = 1'b1;
        o_mem_wr   = 1'b0;
        o_mem_data = 8'h00;
        if (r_state == S_XFER) begin
            o_mem_cs   = 1'b0;
            o_mem_wr   = r_op;
            o_mem_data = r_op ? w_wr_byte : 8'h00;
        end
    end

    // r_addr is the live memory address; it stops on the last byte so it holds afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt     <= '0;
            r_op      <= 1'b0;
            r_wdata   <= '0;
            r_rbuf    <= '0;
            r_rd_data <= '0;
            r_addr    <= '0;
        end else if (w_accept) begin
            r_cnt   <= '0;
            r_op    <= i_op;
            r_wdata <= i_wr_data;
            r_addr  <= i_addr;
        end else if (r_state == S_XFER) begin
            if (!r_op) begin
                r_rbuf <= w_rbuf_next;
                if (w_last) r_rd_data <= w_rbuf_next;
            end
            if (!w_last) begin
                r_cnt  <= r_cnt + CNT_W'(1);
                r_addr <= r_addr + ADDR_W'(1);
            end
        end
    end

    assign o_mem_address = r_addr;
    assign o_rd_data     = r_rd_data;

endmodule

// File: doc/memory_word_transfer_unit.md
MEMORY_WORD_TRANSFER_UNIT -- requirements
Module: memory_word_transfer_unit

Interface
REQ-001 Parameter DATA_W, default 16, word width in bits; SHALL be a multiple of 8 in the range 8..64; NBYTES = DATA_W/8.
REQ-002 Parameter ADDR_W, default 16, byte-address width.
REQ-003 Parameter BIG_ENDIAN, default 0; 0 = byte i holds word bits [8i+7:8i]; 1 = byte i holds word bits [DATA_W-1-8i : DATA_W-8-8i].
REQ-004 Clock  input  1  single clock; all state changes on its rising edge.
REQ-005 Reset  input  1  asynchronous, active-low reset.
REQ-006 Start  input  1  request a transfer; sampled only in IDLE.
REQ-007 Op  input  1  0 = load word, 1 = store word.
REQ-008 Addr  input  ADDR_W  base byte address.
REQ-009 WrData  input  DATA_W  store word.
REQ-010 MemOut  input  8  memory read byte; combinational from Mem_Address while Mem_CS=0 and Mem_WR=0.
REQ-011 Mem_Address  output  ADDR_W  byte address to memory.
REQ-012 Mem_Data  output  8  byte to be written.
REQ-013 Mem_WR  output  1  1 = write; memory commits the write at the rising edge while Mem_CS=0.
REQ-014 Mem_CS  output  1  active-low chip select.
REQ-015 RdData  output  DATA_W  last completed load word.
REQ-016 Busy  output  1  high in any state other than IDLE.
REQ-017 Done  output  1  one-cycle completion pulse.

Function
REQ-018 The FSM SHALL have three states: IDLE, XFER, DONE.
- IDLE -> XFER on a rising edge with Start=1.
- XFER -> DONE after the byte with index NBYTES-1.
- DONE -> IDLE unconditionally.
REQ-019 On acceptance, the block SHALL latch Addr, Op and WrData and clear the byte counter; input changes after acceptance SHALL have no effect.
REQ-020 Start SHALL be ignored in XFER and DONE; requests are not queued.
REQ-021 In XFER, byte cycle i (0..NBYTES-1) SHALL drive:
- Mem_CS=0;
- Mem_Address = (base + i) mod 2^ADDR_W;
- store: Mem_WR=1 and Mem_Data = byte i of the latched WrData;
- load: Mem_WR=0, with MemOut captured into internal byte i at the closing edge.
REQ-022 Address wrap-around SHALL be silent; there is no error flag.
REQ-023 Outside XFER, the block SHALL drive Mem_CS=1, Mem_WR=0 and Mem_Data=0, and Mem_Address SHALL hold its last value.
REQ-024 Done SHALL be 1 only in DONE, exactly NBYTES+1 cycles after the accepting edge; Busy SHALL also be 1 during DONE.
REQ-025 RdData SHALL update only on the XFER->DONE edge of a load, then hold until the next completed load; stores SHALL never change RdData.
REQ-026 The byte order of the assembled load word SHALL follow BIG_ENDIAN exactly as for stores, so a store followed by a load at the same address returns the same word.
REQ-027 With NBYTES=1, XFER SHALL last exactly one cycle.

Reset
REQ-028 Reset=0 SHALL immediately force:
- state IDLE, byte counter 0;
- Busy=0, Done=0, Mem_CS=1, Mem_WR=0, Mem_Data=0;
- Mem_Address=0, RdData=0.
REQ-029 Reset during XFER SHALL abort the transfer: bytes already committed remain in memory, no further bytes are written, Done does not pulse, and RdData=0.
REQ-030 After Reset deasserts, the first Start SHALL be accepted on the first rising edge.

Verification
REQ-031 Reset held low for 3 cycles -> Busy=0, Done=0, Mem_CS=1, Mem_WR=0, RdData=0x0000.
REQ-032 DATA_W=16, BIG_ENDIAN=0, store Addr=0x0040, WrData=0xBEEF -> cycle 1: Mem_Address=0x0040, Mem_Data=0xEF, Mem_WR=1, Mem_CS=0; cycle 2: 0x0041, 0xBE; cycle 3: Done=1; cycle 4: Busy=0.
REQ-033 Load Addr=0x0040 after REQ-032 -> RdData=0xBEEF at Done, RdData unchanged before Done; the same sequence with BIG_ENDIAN=1 and bytes 0xEF, 0xBE stored -> RdData=0xEFBE.
REQ-034 Store Addr=0xFFFF, WrData=0x1234 -> byte 0x34 at 0xFFFF, byte 0x12 at 0x0000, Done 3 cycles after Start.
REQ-035 Start pulsed again during XFER -> ignored, exactly one Done; Reset asserted after byte 0 of a store to 0x0040 -> 0x0040 written, 0x0041 unchanged, no Done.
REQ-036 DATA_W=32, load from 0x0100 holding bytes 0x11, 0x22, 0x33, 0x44 -> 4 read cycles, Done at cycle 5, RdData=0x44332211.
